alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 167 ++++++++++++++++
 tb/tb_alu_rs.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of a single-cycle ALU.
// Holds up to RS_DEPTH dispatched operations. It wakes waiting operands from
// the common data bus and issues the lowest-index ready entry to the ALU,
// leaving at least one gap cycle between two issues.
module alu_rs #(
    parameter int ROB_IX   = 2,
    parameter int RS_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dispatch_valid_in,
    output logic              dispatch_ready_out,
    input  logic [3:0]        aluFunc_in,
    input  logic [ROB_IX:0]   rob_ix_in,
    input  logic              src1_ready_in,
    input  logic              src2_ready_in,
    input  logic [31:0]       src1_val_in,
    input  logic [31:0]       src2_val_in,
    input  logic [ROB_IX:0]   src1_tag_in,
    input  logic [ROB_IX:0]   src2_tag_in,
    input  logic              cdb_valid_in,
    input  logic [ROB_IX:0]   cdb_tag_in,
    input  logic [31:0]       cdb_data_in,
    input  logic              flush_in,
    input  logic              alu_ready_in,
    output logic              alu_valid_out,
    output logic [31:0]       alu_rval1_out,
    output logic [31:0]       alu_rval2_out,
    output logic [3:0]        alu_func_out,
    output logic [ROB_IX:0]   alu_rob_ix_out
);

    localparam int IX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    // Entry storage
    logic [RS_DEPTH-1:0] valid_r;
    logic [RS_DEPTH-1:0] s1_rdy_r;
    logic [RS_DEPTH-1:0] s2_rdy_r;
    logic [3:0]          func_r   [RS_DEPTH];
    logic [ROB_IX:0]     rob_r    [RS_DEPTH];
    logic [ROB_IX:0]     s1_tag_r [RS_DEPTH];
    logic [ROB_IX:0]     s2_tag_r [RS_DEPTH];
    logic [31:0]         s1_val_r [RS_DEPTH];
    logic [31:0]         s2_val_r [RS_DEPTH];

    // Issue port registers; alu_valid_r doubles as the issued-last-cycle flag
    logic                alu_valid_r;
    logic [31:0]         alu_rval1_r;
    logic [31:0]         alu_rval2_r;
    logic [3:0]          alu_func_r;
    logic [ROB_IX:0]     alu_rob_r;

    // Combinational decisions
    logic [RS_DEPTH-1:0] eligible_s;
    logic [RS_DEPTH-1:0] cap1_s;
    logic [RS_DEPTH-1:0] cap2_s;
    logic [IX_W-1:0]     free_idx_s;
    logic [IX_W-1:0]     iss_idx_s;
    logic                free_any_s;
    logic                elig_any_s;
    logic                issue_s;
    logic                dispatch_s;
    logic                disp_s1_rdy_s;
    logic                disp_s2_rdy_s;
    logic [31:0]         disp_s1_val_s;
    logic [31:0]         disp_s2_val_s;

    // Priority search for the lowest free slot and lowest eligible slot; CDB match per entry.
    always_comb begin
        eligible_s = valid_r & s1_rdy_r & s2_rdy_r;
        free_any_s = ~(&valid_r);
        elig_any_s = |eligible_s;
        free_idx_s = {IX_W{1'b0}};
        iss_idx_s  = {IX_W{1'b0}};
        cap1_s     = {RS_DEPTH{1'b0}};
        cap2_s     = {RS_DEPTH{1'b0}};
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            free_idx_s = (!valid_r[i])   ? IX_W'(i) : free_idx_s;
            iss_idx_s  = eligible_s[i]   ? IX_W'(i) : iss_idx_s;
            cap1_s[i]  = valid_r[i] & ~s1_rdy_r[i] & cdb_valid_in & (s1_tag_r[i] == cdb_tag_in);
            cap2_s[i]  = valid_r[i] & ~s2_rdy_r[i] & cdb_valid_in & (s2_tag_r[i] == cdb_tag_in);
        end
    end

    // Issue/dispatch qualification and dispatch-time CDB bypass of operands.
    always_comb begin
        issue_s       = elig_any_s & alu_ready_in & ~alu_valid_r & ~flush_in;
        dispatch_s    = dispatch_valid_in & free_any_s & ~flush_in;
        disp_s1_rdy_s = src1_ready_in | (cdb_valid_in & (src1_tag_in == cdb_tag_in));
        disp_s2_rdy_s = src2_ready_in | (cdb_valid_in & (src2_tag_in == cdb_tag_in));
        disp_s1_val_s = src1_ready_in ? src1_val_in : cdb_data_in;
        disp_s2_val_s = src2_ready_in ? src2_val_in : cdb_data_in;
    end

    // Entry state: flush clears all; otherwise dispatch write, issue invalidate, CDB capture.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_r  <= {RS_DEPTH{1'b0}};
            s1_rdy_r <= {RS_DEPTH{1'b0}};
            s2_rdy_r <= {RS_DEPTH{1'b0}};
            for (int i = 0; i < RS_DEPTH; i++) begin
                func_r[i]   <= 4'd0;
                rob_r[i]    <= {(ROB_IX+1){1'b0}};
                s1_tag_r[i] <= {(ROB_IX+1){1'b0}};
                s2_tag_r[i] <= {(ROB_IX+1){1'b0}};
                s1_val_r[i] <= 32'd0;
                s2_val_r[i] <= 32'd0;
            end
        end else if (flush_in) begin
            valid_r <= {RS_DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                // The free slot is never the issuing slot nor a capturing slot.
                if (dispatch_s && (free_idx_s == IX_W'(i))) begin
                    valid_r[i]  <= 1'b1;
                    func_r[i]   <= aluFunc_in;
                    rob_r[i]    <= rob_ix_in;
                    s1_rdy_r[i] <= disp_s1_rdy_s;
                    s2_rdy_r[i] <= disp_s2_rdy_s;
                    s1_tag_r[i] <= src1_tag_in;
                    s2_tag_r[i] <= src2_tag_in;
                    s1_val_r[i] <= disp_s1_val_s;
                    s2_val_r[i] <= disp_s2_val_s;
                end else begin
                    if (issue_s && (iss_idx_s == IX_W'(i))) begin
                        valid_r[i] <= 1'b0;
                    end
                    if (cap1_s[i]) begin
                        s1_rdy_r[i] <= 1'b1;
                        s1_val_r[i] <= cdb_data_in;
                    end
                    if (cap2_s[i]) begin
                        s2_rdy_r[i] <= 1'b1;
                        s2_val_r[i] <= cdb_data_in;
                    end
                end
            end
        end
    end

    // Issue port: one-cycle valid pulse, data held until the next issue.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_valid_r <= 1'b0;
            alu_rval1_r <= 32'd0;
            alu_rval2_r <= 32'd0;
            alu_func_r  <= 4'd0;
            alu_rob_r   <= {(ROB_IX+1){1'b0}};
        end else begin
            alu_valid_r <= issue_s;
            if (issue_s) begin
                alu_rval1_r <= s1_val_r[iss_idx_s];
                alu_rval2_r <= s2_val_r[iss_idx_s];
                alu_func_r  <= func_r[iss_idx_s];
                alu_rob_r   <= rob_r[iss_idx_s];
            end
        end
    end

    assign dispatch_ready_out = free_any_s;
    assign alu_valid_out      = alu_valid_r;
    assign alu_rval1_out      = alu_rval1_r;
    assign alu_rval2_out      = alu_rval2_r;
    assign alu_func_out       = alu_func_r;
    assign alu_rob_ix_out     = alu_rob_r;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic for alu_rs, checked
// every cycle against a behavioural reservation-station model.
module tb_alu_rs;

    localparam int ROB_IX   = 2;
    localparam int RS_DEPTH = 4;
    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              dispatch_valid_in = 1'b0;
    logic              dispatch_ready_out;
    logic [3:0]        aluFunc_in = 4'd0;
    logic [ROB_IX:0]   rob_ix_in = '0;
    logic              src1_ready_in = 1'b0, src2_ready_in = 1'b0;
    logic [31:0]       src1_val_in = 32'd0, src2_val_in = 32'd0;
    logic [ROB_IX:0]   src1_tag_in = '0, src2_tag_in = '0;
    logic              cdb_valid_in = 1'b0;
    logic [ROB_IX:0]   cdb_tag_in = '0;
    logic [31:0]       cdb_data_in = 32'd0;
    logic              flush_in = 1'b0;
    logic              alu_ready_in = 1'b1;
    logic              alu_valid_out;
    logic [31:0]       alu_rval1_out, alu_rval2_out;
    logic [3:0]        alu_func_out;
    logic [ROB_IX:0]   alu_rob_ix_out;

    alu_rs #(.ROB_IX(ROB_IX), .RS_DEPTH(RS_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dispatch_valid_in(dispatch_valid_in), .dispatch_ready_out(dispatch_ready_out),
        .aluFunc_in(aluFunc_in), .rob_ix_in(rob_ix_in),
        .src1_ready_in(src1_ready_in), .src2_ready_in(src2_ready_in),
        .src1_val_in(src1_val_in), .src2_val_in(src2_val_in),
        .src1_tag_in(src1_tag_in), .src2_tag_in(src2_tag_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .flush_in(flush_in), .alu_ready_in(alu_ready_in),
        .alu_valid_out(alu_valid_out), .alu_rval1_out(alu_rval1_out),
        .alu_rval2_out(alu_rval2_out), .alu_func_out(alu_func_out),
        .alu_rob_ix_out(alu_rob_ix_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: slots hold pending ops; outputs mirror the last issue.
    typedef struct {
        bit          v;
        logic [3:0]  f;
        logic [2:0]  rob;
        bit          r1, r2;
        logic [2:0]  t1, t2;
        logic [31:0] d1, d2;
    } ent_t;

    ent_t        m_rs [RS_DEPTH];
    bit          m_av;
    logic [31:0] m_o1, m_o2;
    logic [3:0]  m_of;
    logic [2:0]  m_orob;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_free();
        bit f = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) if (!m_rs[i].v) f = 1'b1;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_DEPTH; i++) m_rs[i] = '{default: 0};
        m_av = 1'b0; m_o1 = 32'd0; m_o2 = 32'd0; m_of = 4'd0; m_orob = 3'd0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        ent_t nx [RS_DEPTH];
        int   iss = -1;
        int   fr  = -1;
        bit   did_issue;
        if (!rst_in) begin
            model_reset();
            return;
        end
        nx = m_rs;
        if (flush_in) begin
            for (int i = 0; i < RS_DEPTH; i++) nx[i].v = 1'b0;
            m_rs = nx;
            m_av = 1'b0;
            return;
        end
        for (int i = 0; i < RS_DEPTH; i++)
            if (iss < 0 && m_rs[i].v && m_rs[i].r1 && m_rs[i].r2) iss = i;
        for (int i = 0; i < RS_DEPTH; i++)
            if (fr < 0 && !m_rs[i].v) fr = i;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (m_rs[i].v && cdb_valid_in) begin
                if (!m_rs[i].r1 && m_rs[i].t1 == cdb_tag_in) begin nx[i].r1 = 1'b1; nx[i].d1 = cdb_data_in; end
                if (!m_rs[i].r2 && m_rs[i].t2 == cdb_tag_in) begin nx[i].r2 = 1'b1; nx[i].d2 = cdb_data_in; end
            end
        end
        did_issue = (iss >= 0) && alu_ready_in && !m_av;
        if (did_issue) begin
            nx[iss].v = 1'b0;
            m_o1 = m_rs[iss].d1; m_o2 = m_rs[iss].d2;
            m_of = m_rs[iss].f;  m_orob = m_rs[iss].rob;
        end
        m_av = did_issue;
        if (dispatch_valid_in && fr >= 0) begin
            nx[fr].v   = 1'b1;
            nx[fr].f   = aluFunc_in;
            nx[fr].rob = rob_ix_in;
            nx[fr].t1  = src1_tag_in;
            nx[fr].t2  = src2_tag_in;
            nx[fr].r1  = src1_ready_in || (cdb_valid_in && src1_tag_in == cdb_tag_in);
            nx[fr].r2  = src2_ready_in || (cdb_valid_in && src2_tag_in == cdb_tag_in);
            nx[fr].d1  = src1_ready_in ? src1_val_in : cdb_data_in;
            nx[fr].d2  = src2_ready_in ? src2_val_in : cdb_data_in;
        end
        m_rs = nx;
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("dispatch_ready", {31'd0, dispatch_ready_out}, {31'd0, model_free()});
            chk("alu_valid", {31'd0, alu_valid_out}, {31'd0, m_av});
            chk("alu_rval1", alu_rval1_out, m_o1);
            chk("alu_rval2", alu_rval2_out, m_o2);
            chk("alu_func", {28'd0, alu_func_out}, {28'd0, m_of});
            chk("alu_rob_ix", {29'd0, alu_rob_ix_out}, {29'd0, m_orob});
        end
    end

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        dispatch_valid_in = 1'b0;
        cdb_valid_in      = 1'b0;
        flush_in          = 1'b0;
    endtask

    task automatic disp(input logic [3:0] f, input logic [2:0] rob,
                        input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [2:0] t2);
        dispatch_valid_in = 1'b1;
        aluFunc_in = f; rob_ix_in = rob;
        src1_ready_in = r1; src1_val_in = v1; src1_tag_in = t1;
        src2_ready_in = r2; src2_val_in = v2; src2_tag_in = t2;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [31:0] d);
        cdb_valid_in = 1'b1; cdb_tag_in = t; cdb_data_in = d;
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        #2;
        chk("reset_dispatch_ready", {31'd0, dispatch_ready_out}, 32'd1);
        chk("reset_alu_valid", {31'd0, alu_valid_out}, 32'd0);
        chk("reset_rval1", alu_rval1_out, 32'd0);
        #21 rst_in = 1'b1;

        // Ready dispatch: one-cycle pulse, data held afterwards.
        alu_ready_in = 1'b1;
        disp(F_ADD, 3'd3, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0);
        step();
        chk("ready_no_early_issue", {31'd0, alu_valid_out}, 32'd0);
        step();
        chk("ready_issue_valid", {31'd0, alu_valid_out}, 32'd1);
        chk("ready_rval1", alu_rval1_out, 32'd5);
        chk("ready_rval2", alu_rval2_out, 32'd7);
        chk("ready_rob", {29'd0, alu_rob_ix_out}, 32'd3);
        step();
        chk("ready_pulse_end", {31'd0, alu_valid_out}, 32'd0);
        chk("ready_hold_rval1", alu_rval1_out, 32'd5);

        // Wakeup via CDB two cycles after dispatch.
        disp(F_SUB, 3'd1, 1'b1, 32'd10, 3'd0, 1'b0, 32'd0, 3'd2);
        step();
        step();
        cdb(3'd2, 32'd4);
        step();
        chk("wake_not_yet", {31'd0, alu_valid_out}, 32'd0);
        step();
        chk("wake_issue", {31'd0, alu_valid_out}, 32'd1);
        chk("wake_rval1", alu_rval1_out, 32'd10);
        chk("wake_rval2", alu_rval2_out, 32'd4);
        chk("wake_func", {28'd0, alu_func_out}, {28'd0, F_SUB});
        step();
        // Same-cycle bypass at dispatch.
        disp(F_SUB, 3'd2, 1'b1, 32'd10, 3'd0, 1'b0, 32'd0, 3'd2);
        cdb(3'd2, 32'd4);
        step();
        step();
        chk("bypass_issue", {31'd0, alu_valid_out}, 32'd1);
        chk("bypass_rval2", alu_rval2_out, 32'd4);
        step();

        // Full station: fifth dispatch dropped, one wakeup frees a slot.
        for (int i = 0; i < 4; i++) begin
            disp(F_ADD, 3'(i), 1'b0, 32'd0, 3'(4 + i), 1'b1, 32'(i), 3'd0);
            step();
        end
        chk("full_not_ready", {31'd0, dispatch_ready_out}, 32'd0);
        disp(F_ADD, 3'd7, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
        step();
        chk("full_drop_no_issue", {31'd0, alu_valid_out}, 32'd0);
        cdb(3'd5, 32'h55);
        step();
        step();
        chk("full_wake_issue", {31'd0, alu_valid_out}, 32'd1);
        chk("full_wake_rval1", alu_rval1_out, 32'h55);
        chk("full_wake_rob", {29'd0, alu_rob_ix_out}, 32'd1);
        chk("full_ready_again", {31'd0, dispatch_ready_out}, 32'd1);
        flush_in = 1'b1;
        step();

        // Back-pressure and the mandatory gap cycle.
        alu_ready_in = 1'b0;
        disp(F_ADD, 3'd1, 1'b1, 32'h11, 3'd0, 1'b1, 32'h21, 3'd0);
        step();
        disp(F_ADD, 3'd2, 1'b1, 32'h12, 3'd0, 1'b1, 32'h22, 3'd0);
        step();
        step();
        chk("bp_no_issue", {31'd0, alu_valid_out}, 32'd0);
        alu_ready_in = 1'b1;
        step();
        chk("bp_first_issue", {29'd0, alu_rob_ix_out}, 32'd1);
        step();
        chk("bp_gap", {31'd0, alu_valid_out}, 32'd0);
        step();
        chk("bp_second_issue", {31'd0, alu_valid_out}, 32'd1);
        chk("bp_second_rob", {29'd0, alu_rob_ix_out}, 32'd2);
        step();

        // Flush discards pending entries; stale CDB tags have no effect.
        for (int i = 1; i <= 3; i++) begin
            disp(F_ADD, 3'(i), 1'b1, 32'd1, 3'd0, 1'b0, 32'd0, 3'(i));
            step();
        end
        flush_in = 1'b1;
        step();
        chk("flush_no_issue", {31'd0, alu_valid_out}, 32'd0);
        chk("flush_ready", {31'd0, dispatch_ready_out}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cdb(3'(i), 32'hDEAD);
            step();
            chk("flush_stale_cdb", {31'd0, alu_valid_out}, 32'd0);
        end
        step();

        // Asynchronous reset between edges while an issue is in flight.
        disp(F_ADD, 3'd6, 1'b1, 32'd9, 3'd0, 1'b1, 32'd8, 3'd0);
        step();
        disp(F_ADD, 3'd5, 1'b0, 32'd0, 3'd7, 1'b1, 32'd1, 3'd0);
        step();
        disp(F_ADD, 3'd4, 1'b0, 32'd0, 3'd7, 1'b1, 32'd1, 3'd0);
        step();
        #2 rst_in = 1'b0;
        model_reset();
        #1;
        chk("areset_alu_valid", {31'd0, alu_valid_out}, 32'd0);
        chk("areset_ready", {31'd0, dispatch_ready_out}, 32'd1);
        chk("areset_rval1", alu_rval1_out, 32'd0);
        step();
        #3 rst_in = 1'b1;
        disp(F_SUB, 3'd2, 1'b1, 32'd30, 3'd0, 1'b1, 32'd12, 3'd0);
        step();
        step();
        chk("post_reset_issue", {31'd0, alu_valid_out}, 32'd1);
        chk("post_reset_rval1", alu_rval1_out, 32'd30);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            alu_ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                disp(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 4) < 2)
                cdb(3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 39) == 0)
                flush_in = 1'b1;
            step();
        end

        @(negedge clk_in);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
